// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state type and constants for the UART TX arbiter
package uart_arb_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_e;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: cyclic first-set search of i_req starting at i_ptr, wrapping at N
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_found,
  output logic [W-1:0] o_idx
);
  logic [N-1:0] w_rot;
  assign o_found = |i_req;
  always_comb begin
    w_rot = N'({i_req, i_req} >> i_ptr);
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (w_rot[k]) o_idx = W'(({1'b0, i_ptr} + (W+1)'(k)) % (W+1)'(N));
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked arbiter sharing one UART TX; define UART_ARB_FIXED_PRIO_EN for fixed priority
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_valid,
  output logic [BYTE_W-1:0]           tx_data,
  input  logic                        tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        timeout
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  arb_state_e     r_state, w_state_nx;
  logic [IDW-1:0] r_grant, w_rr_ptr, w_pick;
  logic [CW-1:0]  r_cnt;
  logic           w_locked, w_found, w_xfer, w_expire, w_release;

  rr_picker #(.N(NUM_REQ), .W(IDW)) u_pick (
    .i_req   (req_valid),
    .i_ptr   (w_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

`ifdef UART_ARB_FIXED_PRIO_EN
  assign w_rr_ptr = '0;
`else
  logic [IDW-1:0] r_rr_ptr, w_g_next;
  assign w_g_next = r_grant == IDW'(NUM_REQ - 1) ? '0 : r_grant + IDW'(1);
  always_ff @(posedge clk)
    if (reset) r_rr_ptr <= '0;
    else if (w_release) r_rr_ptr <= w_g_next;
  assign w_rr_ptr = r_rr_ptr;
`endif

  assign w_locked  = r_state == LOCKED;
  assign w_xfer    = w_locked && req_valid[r_grant] && tx_ready;
  // a transfer in the expiry cycle wins over the timeout
  assign w_expire  = w_locked && !w_xfer && r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign w_release = (w_xfer && req_last[r_grant]) || w_expire;

  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_state_nx;

  always_comb
    w_state_nx = !w_locked ? (w_found ? LOCKED : IDLE) : (w_release ? IDLE : LOCKED);

  always_ff @(posedge clk)
    if (reset) begin
      r_grant <= '0;
      r_cnt   <= '0;
    end else begin
      if (!w_locked && w_found) r_grant <= w_pick;
      r_cnt <= (!w_locked || w_xfer || w_expire) ? '0 : r_cnt + CW'(1);
    end

  always_comb begin
    busy      = w_locked;
    grant_id  = r_grant;
    tx_valid  = w_locked && req_valid[r_grant];
    tx_data   = req_data[{r_grant, 3'b000} +: BYTE_W];
    req_ready = w_locked && tx_ready ? NUM_REQ'(1) << r_grant : '0;
    timeout   = w_expire;
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter (2 requesters, 16-cycle timeout)
module tb_uart_tx_arbiter;
  localparam int N  = 2;
  localparam int TO = 16;
  logic           clk = 1'b1, reset = 1'b1;
  logic [N-1:0]   req_valid = '0, req_last = '0, req_ready;
  logic [8*N-1:0] req_data = '0;
  logic           tx_valid, tx_ready = 1'b0, busy, timeout;
  logic [7:0]     tx_data;
  logic [0:0]     grant_id;
  typedef struct {int id; logic [7:0] d; int cyc;} exp_t;
  exp_t       sb[$];
  logic [8:0] src0[$], src1[$];
  int   cyc = 0, n_chk = 0, n_pass = 0, n_to = 0, to_cyc = -1;
  int   rdy_mode = 0, rdy_at = 0, chk_rst_at = -1;
  logic held_v = 1'b0;
  logic [7:0] held_d = '0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .timeout   (timeout)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  task automatic drive();
    req_valid[0] = src0.size() > 0;
    {req_last[0], req_data[7:0]} = src0.size() > 0 ? src0[0] : 9'h0;
    req_valid[1] = src1.size() > 0;
    {req_last[1], req_data[15:8]} = src1.size() > 0 ? src1[0] : 9'h0;
    tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? cyc[0] : cyc >= rdy_at;
  endtask

  task automatic monitor();
    exp_t e;
    if (cyc == chk_rst_at) begin
      check("rst_busy", busy, 0);
      check("rst_gid", grant_id, 0);
      check("rst_timeout", timeout, 0);
    end
    if (!busy) check("idle_out", {tx_valid, req_ready}, 0);
    if (timeout) begin
      n_to++;
      to_cyc = cyc;
    end
    if (held_v && tx_valid) check("hold", tx_data, held_d);
    held_v = tx_valid && !tx_ready;
    held_d = tx_data;
    if (tx_valid && tx_ready) begin
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("data", tx_data, e.d);
        check("gid", grant_id, e.id);
        check("ready", req_ready, 1 << e.id);
        if (e.cyc >= 0) check("cycle", cyc, e.cyc);
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] hs;
    @(negedge clk);
    monitor();
    hs = req_valid & req_ready;
    @(posedge clk);
    cyc++;
    #1;
    if (hs[0] && src0.size() > 0) void'(src0.pop_front());
    if (hs[1] && src1.size() > 0) void'(src1.pop_front());
    drive();
  endtask

  task automatic pkt(int id, int n, logic [7:0] base, bit last, int start);
    logic [8:0] b;
    for (int k = 0; k < n; k++) begin
      b = {last && k == n - 1, base + 8'(k)};
      if (id == 0) src0.push_back(b);
      else src1.push_back(b);
      sb.push_back('{id, b[7:0], start < 0 ? -1 : start + k});
    end
  endtask

  task automatic drain(int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) tick();
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int s, t0;
    drive();
    tick();
    tick();
    reset = 1'b0;
    chk_rst_at = cyc;
    s = cyc;
`ifdef UART_ARB_FIXED_PRIO_EN
    pkt(0, 2, 8'h01, 1, s + 1);
    pkt(0, 2, 8'h03, 1, s + 4);
    pkt(1, 2, 8'h11, 1, s + 7);
    pkt(1, 2, 8'h13, 1, s + 10);
`else
    pkt(0, 2, 8'h01, 1, s + 1);
    pkt(1, 2, 8'h11, 1, s + 4);
    pkt(0, 2, 8'h03, 1, s + 7);
    pkt(1, 2, 8'h13, 1, s + 10);
`endif
    drive();
    drain(30);
    s = cyc;
    pkt(0, 3, 8'h41, 1, s + 1);
    drive();
    drain(10);
    check("single_busy_fall", busy, 0);
    rdy_mode = 1;
    pkt(0, 4, 8'h20, 1, -1);
    drive();
    drain(40);
    rdy_mode = 0;
    s = cyc;
    pkt(0, 2, 8'h10, 0, s + 1);
    src0.push_back(9'h012);
    src0.push_back(9'h113);
    drive();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    src0.delete();
    chk_rst_at = s + 3;
    pkt(0, 1, 8'hA0, 1, s + 4);
    pkt(1, 1, 8'hB0, 1, s + 6);
    drive();
    drain(20);
    s = cyc;
    t0 = n_to;
    pkt(1, 1, 8'h55, 0, s + 1);
    drive();
    tick();
    tick();
    tick();
    pkt(0, 1, 8'h66, 1, s + 19);
    drive();
    drain(40);
    check("to_pulses", n_to - t0, 1);
    check("to_cycle", to_cyc, s + 17);
    s = cyc;
    t0 = n_to;
    rdy_mode = 2;
    rdy_at = s + 16;
    pkt(0, 1, 8'h77, 1, s + 16);
    drive();
    drain(30);
    rdy_mode = 0;
    tick();
    check("last_beats_timeout", n_to - t0, 0);
    check("last_release_busy", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end
endmodule
